// File: rtl/crazy_taxi_pkg.sv
// Shared constants, colours and state encodings for the crazy-taxi VGA draw path.
// Screen and sprite geometry live here so the scheduler and the bench agree on one set of numbers.
package crazy_taxi_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int SPRITE_W   = 16;
  localparam int SPRITE_H   = 16;
  localparam int LANE_X0    = 24;
  localparam int LANE_PITCH = 48;
  localparam int PLAYER_Y   = 100;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ERASE,
    S_DRAW,
    S_DONE
  } draw_state_e;

  typedef enum logic {
    SPR_PLAYER,
    SPR_OBSTACLE
  } sprite_e;

  // The lowest set bit of the one-hot lane wins; an all-zero lane maps to lane 0 but is flagged invalid by the caller.
  function automatic logic [7:0] lane_x(input logic [2:0] lane);
    if (lane[0])      return 8'(LANE_X0);
    else if (lane[1]) return 8'(LANE_X0 + LANE_PITCH);
    else if (lane[2]) return 8'(LANE_X0 + 2 * LANE_PITCH);
    else              return 8'(LANE_X0);
  endfunction

endpackage

// File: rtl/vga_draw_scheduler_rect_walker.sv
// Walks a w x h rectangle row-major (x fastest) one pixel per clock from a latched origin.
// The first pixel is presented in the cycle after start; last_o flags the final pixel.
module rect_walker (
  input  logic       clock_i,
  input  logic       resetn_i,
  input  logic       start_i,
  input  logic [7:0] x0_i,
  input  logic [6:0] y0_i,
  input  logic [7:0] w_i,
  input  logic [6:0] h_i,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic       last_o
);

  logic [7:0] x0_q, w_q, cx_q, cx_d;
  logic [6:0] y0_q, h_q, cy_q, cy_d;
  logic       active_q, active_d;
  logic       row_end;

  // y is kept one bit wider than the screen so rows that fall off the bottom can be recognised and clipped.
  always_comb begin
    row_end  = (cx_q == w_q - 8'd1);
    last_o   = active_q && row_end && (cy_q == h_q - 7'd1);
    x_o      = x0_q + cx_q;
    y_o      = {1'b0, y0_q} + {1'b0, cy_q};
    cx_d     = cx_q;
    cy_d     = cy_q;
    active_d = active_q;
    if (start_i) begin
      cx_d     = '0;
      cy_d     = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last_o) begin
        active_d = 1'b0;
      end else if (row_end) begin
        cx_d = '0;
        cy_d = cy_q + 7'd1;
      end else begin
        cx_d = cx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      active_q <= 1'b0;
    end else begin
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      active_q <= active_d;
      if (start_i) begin
        x0_q <= x0_i;
        y0_q <= y0_i;
        w_q  <= w_i;
        h_q  <= h_i;
      end
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Arbitrates clear / obstacle / player redraw jobs onto the single VGA adapter plot port.
// Requests are latched as pending flags and served one at a time by fixed priority.
module vga_draw_scheduler
  import crazy_taxi_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetn_i,
  input  logic       req_clear_i,
  input  logic       req_obstacle_i,
  input  logic       req_player_i,
  input  logic [2:0] bg_colour_i,
  input  logic [2:0] player_lane_i,
  input  logic [2:0] obstacle_lane_i,
  input  logic [6:0] obstacle_y_i,
  input  logic [2:0] player_colour_i,
  input  logic [2:0] obstacle_colour_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [2:0] colour_o,
  output logic       plot_o,
  output logic       busy_o,
  output logic       done_o
);

  draw_state_e state_q, state_d;
  sprite_e     sprite_q, sprite_d;

  logic pend_clear_q, pend_clear_d, pend_obs_q, pend_obs_d, pend_player_q, pend_player_d;
  logic grant_clear, grant_obs, grant_player, erase, clear_prev, store_prev, walking;

  logic [2:0] bg_q, bg_d, ink_q, ink_d;
  logic [7:0] new_x_q, new_x_d;
  logic [6:0] new_y_q, new_y_d;
  logic       new_valid_q, new_valid_d;

  logic [7:0] prev_px_q, prev_ox_q;
  logic [6:0] prev_py_q, prev_oy_q;
  logic       prev_valid_p_q, prev_valid_o_q;

  logic [7:0] pix_x_d;
  logic [6:0] pix_y_d;
  logic [2:0] pix_c_d;
  logic       plot_d;

  logic       w_start, w_last;
  logic [7:0] w_x0, w_w, w_x, w_y;
  logic [6:0] w_y0, w_h;

  rect_walker u_walker (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .start_i  (w_start),
    .x0_i     (w_x0),
    .y0_i     (w_y0),
    .w_i      (w_w),
    .h_i      (w_h),
    .x_o      (w_x),
    .y_o      (w_y),
    .last_o   (w_last)
  );

  // Job inputs are snapshotted at grant; the walker is restarted seamlessly when ERASE hands over to DRAW.
  always_comb begin
    state_d      = state_q;
    sprite_d     = sprite_q;
    bg_d         = bg_q;
    ink_d        = ink_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_valid_d  = new_valid_q;
    grant_clear  = 1'b0;
    grant_obs    = 1'b0;
    grant_player = 1'b0;
    erase        = 1'b0;
    clear_prev   = 1'b0;
    store_prev   = 1'b0;
    w_start      = 1'b0;
    w_x0         = new_x_q;
    w_y0         = new_y_q;
    w_w          = 8'(SPRITE_W);
    w_h          = 7'(SPRITE_H);
    case (state_q)
      S_IDLE: begin
        if (pend_clear_q) begin
          grant_clear = 1'b1;
          bg_d        = bg_colour_i;
          w_start     = 1'b1;
          w_x0        = '0;
          w_y0        = '0;
          w_w         = 8'(SCREEN_W);
          w_h         = 7'(SCREEN_H);
          state_d     = S_CLEAR;
        end else if (pend_obs_q || pend_player_q) begin
          bg_d    = bg_colour_i;
          w_start = 1'b1;
          if (pend_obs_q) begin
            grant_obs   = 1'b1;
            sprite_d    = SPR_OBSTACLE;
            new_x_d     = lane_x(obstacle_lane_i);
            new_y_d     = obstacle_y_i;
            new_valid_d = |obstacle_lane_i;
            ink_d       = obstacle_colour_i;
            erase       = prev_valid_o_q;
            w_x0        = prev_ox_q;
            w_y0        = prev_oy_q;
          end else begin
            grant_player = 1'b1;
            sprite_d     = SPR_PLAYER;
            new_x_d      = lane_x(player_lane_i);
            new_y_d      = 7'(PLAYER_Y);
            new_valid_d  = |player_lane_i;
            ink_d        = player_colour_i;
            erase        = prev_valid_p_q;
            w_x0         = prev_px_q;
            w_y0         = prev_py_q;
          end
          if (erase) begin
            state_d = S_ERASE;
          end else begin
            w_x0    = new_x_d;
            w_y0    = new_y_d;
            state_d = S_DRAW;
          end
        end
      end
      S_CLEAR: if (w_last) begin
        clear_prev = 1'b1;
        state_d    = S_DONE;
      end
      S_ERASE: if (w_last) begin
        w_start = 1'b1;
        state_d = S_DRAW;
      end
      S_DRAW: if (w_last) begin
        store_prev = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A request landing in its own grant or finish cycle re-arms the flag rather than being absorbed.
    pend_clear_d  = (pend_clear_q  & ~grant_clear)  | req_clear_i;
    pend_obs_d    = (pend_obs_q    & ~grant_obs)    | req_obstacle_i;
    pend_player_d = (pend_player_q & ~grant_player) | req_player_i;

    walking = (state_q == S_CLEAR) || (state_q == S_ERASE) || (state_q == S_DRAW);
    pix_x_d = '0;
    pix_y_d = '0;
    pix_c_d = BLACK;
    plot_d  = 1'b0;
    if (walking) begin
      pix_x_d = w_x;
      pix_y_d = w_y[6:0];
      pix_c_d = (state_q == S_DRAW) ? ink_q : bg_q;
      plot_d  = (w_y < 8'(SCREEN_H)) && ((state_q != S_DRAW) || new_valid_q);
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q        <= S_IDLE;
      sprite_q       <= SPR_PLAYER;
      pend_clear_q   <= 1'b0;
      pend_obs_q     <= 1'b0;
      pend_player_q  <= 1'b0;
      bg_q           <= '0;
      ink_q          <= '0;
      new_x_q        <= '0;
      new_y_q        <= '0;
      new_valid_q    <= 1'b0;
      prev_px_q      <= '0;
      prev_py_q      <= '0;
      prev_ox_q      <= '0;
      prev_oy_q      <= '0;
      prev_valid_p_q <= 1'b0;
      prev_valid_o_q <= 1'b0;
      x_o            <= '0;
      y_o            <= '0;
      colour_o       <= '0;
      plot_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sprite_q      <= sprite_d;
      pend_clear_q  <= pend_clear_d;
      pend_obs_q    <= pend_obs_d;
      pend_player_q <= pend_player_d;
      bg_q          <= bg_d;
      ink_q         <= ink_d;
      new_x_q       <= new_x_d;
      new_y_q       <= new_y_d;
      new_valid_q   <= new_valid_d;
      x_o           <= pix_x_d;
      y_o           <= pix_y_d;
      colour_o      <= pix_c_d;
      plot_o        <= plot_d;
      if (clear_prev) begin
        prev_valid_p_q <= 1'b0;
        prev_valid_o_q <= 1'b0;
      end else if (store_prev) begin
        if (sprite_q == SPR_PLAYER) begin
          prev_px_q      <= new_x_q;
          prev_py_q      <= new_y_q;
          prev_valid_p_q <= new_valid_q;
        end else begin
          prev_ox_q      <= new_x_q;
          prev_oy_q      <= new_y_q;
          prev_valid_o_q <= new_valid_q;
        end
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: a job-level model predicts every plotted pixel and done pulse with its cycle.
// The monitor pops and compares whenever the DUT plots or signals done.
module tb_vga_draw_scheduler;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       reqClear = 1'b0, reqObstacle = 1'b0, reqPlayer = 1'b0;
  logic [2:0] bgColour = '0, playerLane = '0, obstacleLane = '0;
  logic [6:0] obstacleY = '0;
  logic [2:0] playerColour = '0, obstacleColour = '0;
  logic [7:0] xOut;
  logic [6:0] yOut;
  logic [2:0] colourOut;
  logic       plotOut, busyOut, doneOut;

  vga_draw_scheduler dut (
    .clock_i           (clock),
    .resetn_i          (resetn),
    .req_clear_i       (reqClear),
    .req_obstacle_i    (reqObstacle),
    .req_player_i      (reqPlayer),
    .bg_colour_i       (bgColour),
    .player_lane_i     (playerLane),
    .obstacle_lane_i   (obstacleLane),
    .obstacle_y_i      (obstacleY),
    .player_colour_i   (playerColour),
    .obstacle_colour_i (obstacleColour),
    .x_o               (xOut),
    .y_o               (yOut),
    .colour_o          (colourOut),
    .plot_o            (plotOut),
    .busy_o            (busyOut),
    .done_o            (doneOut)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit isDone;
    int cycle;
    int x;
    int y;
    int colour;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0, failures = 0;
  int   plotCount = 0, doneCount = 0;

  bit   mPend[3];
  bit   pValid[2];
  int   pX[2], pY[2];
  int   nextGrant = 0;
  int   jobPix;

  task automatic checkOutput(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s: %s", name, detail);
    end
  endtask

  function automatic int laneIdx(input logic [2:0] l);
    for (int i = 0; i < 3; i++) if (l[i]) return i;
    return -1;
  endfunction

  task automatic pushRect(input int x0, input int y0, input int w, input int h, input int colour, input bit en, input int k);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        if (en && (y0 + yy) < 120) expQ.push_back(exp_t'{1'b0, k + 1 + jobPix, x0 + xx, y0 + yy, colour});
        jobPix++;
      end
  endtask

  // Job-level reference: whole jobs are granted when the previous one has fully retired, pixel k lands k+1 cycles after grant.
  task automatic modelStep(input int k, input bit rc, input bit ro, input bit rp);
    int s, idx, nx, ny;
    if (k >= nextGrant && (mPend[0] || mPend[1] || mPend[2])) begin
      jobPix = 0;
      if (mPend[0]) begin
        mPend[0] = 1'b0;
        pushRect(0, 0, 160, 120, int'(bgColour), 1'b1, k);
        pValid[0] = 1'b0;
        pValid[1] = 1'b0;
      end else begin
        s = mPend[1] ? 1 : 0;
        if (s == 1) mPend[1] = 1'b0; else mPend[2] = 1'b0;
        if (pValid[s]) pushRect(pX[s], pY[s], 16, 16, int'(bgColour), 1'b1, k);
        idx = laneIdx(s == 1 ? obstacleLane : playerLane);
        nx  = (idx < 0) ? 0 : 24 + idx * 48;
        ny  = (s == 1) ? int'(obstacleY) : 100;
        pushRect(nx, ny, 16, 16, int'(s == 1 ? obstacleColour : playerColour), idx >= 0, k);
        pValid[s] = (idx >= 0);
        pX[s] = nx;
        pY[s] = ny;
      end
      expQ.push_back(exp_t'{1'b1, k + jobPix, 0, 0, 0});
      nextGrant = k + jobPix + 2;
    end
    if (rc) mPend[0] = 1'b1;
    if (ro) mPend[1] = 1'b1;
    if (rp) mPend[2] = 1'b1;
  endtask

  task automatic applyStimulus(input bit rc, input bit ro, input bit rp, input bit rnd);
    @(negedge clock);
    if (rnd) begin
      bgColour       = 3'($urandom_range(0, 7));
      playerLane     = 3'($urandom_range(0, 7));
      obstacleLane   = 3'($urandom_range(0, 7));
      obstacleY      = 7'($urandom_range(0, 127));
      playerColour   = 3'($urandom_range(0, 7));
      obstacleColour = 3'($urandom_range(0, 7));
    end
    reqClear    = rc;
    reqObstacle = ro;
    reqPlayer   = rp;
    modelStep(cyc + 1, rc, ro, rp);
  endtask

  task automatic runUntilIdle(input bit rnd);
    int guard = 0;
    while ((cyc + 1 < nextGrant || mPend[0] || mPend[1] || mPend[2]) && guard < 30000) begin
      applyStimulus(1'b0, 1'b0, 1'b0, rnd);
      guard++;
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, rnd);
  endtask

  task automatic modelReset();
    expQ.delete();
    mPend  = '{3{1'b0}};
    pValid = '{2{1'b0}};
    nextGrant = 0;
  endtask

  // Monitor: every plot and done pulse must match the head of the expected queue, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (plotOut === 1'b1) begin
        plotCount++;
        if (expQ.size() == 0 || expQ[0].isDone)
          checkOutput("pixel", 1'b0, $sformatf("unexpected plot cyc=%0d (%0d,%0d) c=%0d, required no plot", cyc, xOut, yOut, colourOut));
        else begin
          e = expQ.pop_front();
          checkOutput("pixel", e.cycle == cyc && e.x == int'(xOut) && e.y == int'(yOut) && e.colour == int'(colourOut),
            $sformatf("got cyc=%0d (%0d,%0d) c=%0d, required cyc=%0d (%0d,%0d) c=%0d", cyc, xOut, yOut, colourOut, e.cycle, e.x, e.y, e.colour));
        end
      end
      if (doneOut === 1'b1) begin
        doneCount++;
        if (expQ.size() == 0 || !expQ[0].isDone)
          checkOutput("done", 1'b0, $sformatf("unexpected done at cyc=%0d, required no done yet", cyc));
        else begin
          e = expQ.pop_front();
          checkOutput("done", e.cycle == cyc && busyOut === 1'b1,
            $sformatf("got done cyc=%0d busy=%0b, required cyc=%0d busy=1", cyc, busyOut, e.cycle));
        end
      end
      while (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
        e = expQ.pop_front();
        checkOutput("missing", 1'b0, $sformatf("nothing seen at cyc=%0d, required %s (%0d,%0d) c=%0d",
          e.cycle, e.isDone ? "done" : "plot", e.x, e.y, e.colour));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("reset outputs", xOut === 8'd0 && yOut === 7'd0 && colourOut === 3'd0 && plotOut === 1'b0 && busyOut === 1'b0 && doneOut === 1'b0,
      $sformatf("got x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b, required all 0", xOut, yOut, colourOut, plotOut, busyOut, doneOut));
    #1 resetn = 1'b1;
    modelReset();

    // Full-screen clear in blue.
    bgColour = 3'b001;
    plotCount = 0; doneCount = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runUntilIdle(1'b0);
    checkOutput("clear plots", plotCount == 19200, $sformatf("got %0d, required 19200", plotCount));
    checkOutput("clear done", doneCount == 1, $sformatf("got %0d, required 1", doneCount));
    checkOutput("clear busy after", busyOut === 1'b0, $sformatf("got %0b, required 0", busyOut));

    // First player draw, no erase.
    playerLane = 3'b010; playerColour = 3'b100;
    plotCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runUntilIdle(1'b0);
    checkOutput("player first draw", plotCount == 256, $sformatf("got %0d, required 256", plotCount));

    // Lane move: erase then draw.
    playerLane = 3'b100;
    plotCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runUntilIdle(1'b0);
    checkOutput("player move", plotCount == 512, $sformatf("got %0d, required 512", plotCount));

    // Simultaneous requests; obstacle lane 000 draws nothing.
    obstacleLane = 3'b000; playerLane = 3'b010; obstacleColour = 3'b111;
    plotCount = 0; doneCount = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    runUntilIdle(1'b0);
    checkOutput("triple done", doneCount == 3, $sformatf("got %0d, required 3", doneCount));
    checkOutput("triple plots", plotCount == 19456, $sformatf("got %0d, required 19456", plotCount));

    // Obstacle near the bottom is clipped to rows 112..119.
    obstacleLane = 3'b001; obstacleY = 7'd112; obstacleColour = 3'b100;
    plotCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runUntilIdle(1'b0);
    checkOutput("obstacle clipped", plotCount == 128, $sformatf("got %0d, required 128", plotCount));

    // Reset in the middle of a DRAW with a clear pending.
    playerLane = 3'b001;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (350) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (50) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 resetn = 1'b0;
    modelReset();
    #1 checkOutput("reset mid-job", plotOut === 1'b0 && busyOut === 1'b0 && doneOut === 1'b0,
      $sformatf("got plot=%0b busy=%0b done=%0b, required 0 0 0", plotOut, busyOut, doneOut));
    repeat (2) @(negedge clock);
    #1 resetn = 1'b1;
    plotCount = 0; doneCount = 0;
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pending dropped", plotCount == 0 && doneCount == 0 && busyOut === 1'b0,
      $sformatf("got plots=%0d dones=%0d busy=%0b, required 0 0 0", plotCount, doneCount, busyOut));

    // Randomised sprite traffic with inputs changing every cycle.
    for (int i = 0; i < 20000; i++)
      applyStimulus(1'b0, $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0, 1'b1);
    runUntilIdle(1'b1);

    checkOutput("final idle", busyOut === 1'b0 && plotOut === 1'b0, $sformatf("got busy=%0b plot=%0b, required 0 0", busyOut, plotOut));
    checkOutput("queue drained", expQ.size() == 0, $sformatf("got %0d entries left, required 0", expQ.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
